// File: rtl/riscv_mem_arbiter_n_pkg.sv
// Shared widths and output-stage state encodings for the N-channel memory arbiter.
package riscv_mem_arbiter_n_pkg;

    localparam int MEM_ADDR_BITS = 32;
    localparam int MEM_TAG_BITS  = 4;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_e;

    // Pointer width stays at least one bit so a degenerate channel count still elaborates.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/riscv_mem_arbiter_n_pick.sv
// Grant picker for the memory arbiter: fixed lowest-index priority by default,
// round-robin starting at ptr_i when RISCV_ARB_RR_EN is defined.
module riscv_arb_pick
    import riscv_mem_arbiter_n_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int PTR_W  = ptr_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] grant_o
);

    logic found;

`ifdef RISCV_ARB_RR_EN
    // Offset k from ptr is visited in order; the first eligible channel wins.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && eligible_i[i] && (((int'(ptr_i) + k) % NUM_CH) == i)) begin
                    grant_o[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && eligible_i[i]) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/riscv_mem_arbiter_n.sv
// N-channel memory request arbiter with a one-entry output register and per-channel
// outstanding-request counters. Define RISCV_ARB_RR_EN for a round-robin picker.
module riscv_mem_arbiter_n
    import riscv_mem_arbiter_n_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_BITS = MEM_ADDR_BITS,
    parameter int TAG_BITS  = MEM_TAG_BITS,
    parameter int MAX_OUTST = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           req_valid,
    output logic [NUM_CH-1:0]           req_ready,
    input  logic [NUM_CH-1:0]           req_rw,
    input  logic [NUM_CH*ADDR_BITS-1:0] req_addr,
    output logic [NUM_CH-1:0]           resp_valid,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic                        mem_req_rw,
    output logic [ADDR_BITS-1:0]        mem_req_addr,
    output logic [TAG_BITS-1:0]         mem_req_tag,
    input  logic                        mem_resp_valid,
    input  logic [TAG_BITS-1:0]         mem_resp_tag
);

    localparam int CW    = $clog2(MAX_OUTST + 1);
    localparam int PTR_W = ptr_width(NUM_CH);

    arb_state_e                state_q, state_d;
    logic [NUM_CH-1:0][CW-1:0] outst_q, outst_d;
    logic                      rw_q, rw_d;
    logic [ADDR_BITS-1:0]      addr_q, addr_d;
    logic [TAG_BITS-1:0]       tag_q, tag_d;

    logic [NUM_CH-1:0]         eligible;
    logic [NUM_CH-1:0]         grant;
    logic [PTR_W-1:0]          ptr;
    logic                      can_accept;
    logic                      hs;
    logic [TAG_BITS-1:0]       win;
    logic                      win_rw;
    logic [ADDR_BITS-1:0]      win_addr;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i]   = req_valid[i] && (outst_q[i] < CW'(MAX_OUTST));
            resp_valid[i] = mem_resp_valid && (mem_resp_tag == TAG_BITS'(i));
        end
    end

    riscv_arb_pick #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr),
        .grant_o    (grant)
    );

    // Output-stage FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output-stage FSM: next state. In FULL a handshake implies mem_req_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_EMPTY: if (hs) state_d = ARB_FULL;
            ARB_FULL:  if (mem_req_ready && !hs) state_d = ARB_EMPTY;
            default:   state_d = ARB_EMPTY;
        endcase
    end

    // Output-stage FSM: outputs. The register can take a new entry when empty
    // or when its current entry is leaving this cycle.
    always_comb begin
        mem_req_valid = (state_q == ARB_FULL);
        can_accept    = !reset && ((state_q == ARB_EMPTY) || mem_req_ready);
        req_ready     = can_accept ? grant : '0;
        hs            = |req_ready;
    end

    always_comb begin
        win      = '0;
        win_rw   = 1'b0;
        win_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                win      = TAG_BITS'(i);
                win_rw   = req_rw[i];
                win_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    always_comb begin
        rw_d   = hs ? win_rw   : rw_q;
        addr_d = hs ? win_addr : addr_q;
        tag_d  = hs ? win      : tag_q;
    end

    // A simultaneous issue and response cancel; a stray response never drives a count below zero.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            outst_d[i] = outst_q[i];
            if (req_ready[i] && !resp_valid[i]) begin
                outst_d[i] = outst_q[i] + 1'b1;
            end else if (resp_valid[i] && !req_ready[i] && (outst_q[i] != '0)) begin
                outst_d[i] = outst_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outst_q <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            tag_q   <= '0;
        end else begin
            outst_q <= outst_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
        end
    end

    assign mem_req_rw   = rw_q;
    assign mem_req_addr = addr_q;
    assign mem_req_tag  = tag_q;

`ifdef RISCV_ARB_RR_EN
    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (hs) ptr_d = PTR_W'((int'(win) + 1) % NUM_CH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter_n.sv
// Directed bench for riscv_mem_arbiter_n: a 2-channel and a 4-channel instance share clock and reset.
`timescale 1ns/1ps
module tb_riscv_mem_arbiter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [1:0]   a_valid, a_ready, a_rw, a_resp;
    logic [63:0]  a_addr;
    logic         a_mvalid, a_mready, a_mrw, a_rv;
    logic [31:0]  a_maddr;
    logic [3:0]   a_mtag, a_rtag;

    logic [3:0]   b_valid, b_ready, b_rw, b_resp;
    logic [127:0] b_addr;
    logic         b_mvalid, b_mready, b_mrw, b_rv;
    logic [31:0]  b_maddr;
    logic [3:0]   b_mtag, b_rtag;

    riscv_mem_arbiter_n #(.NUM_CH(2), .ADDR_BITS(32), .TAG_BITS(4), .MAX_OUTST(4)) d2 (
        .clk(clk), .reset(reset),
        .req_valid(a_valid), .req_ready(a_ready), .req_rw(a_rw), .req_addr(a_addr),
        .resp_valid(a_resp),
        .mem_req_valid(a_mvalid), .mem_req_ready(a_mready), .mem_req_rw(a_mrw),
        .mem_req_addr(a_maddr), .mem_req_tag(a_mtag),
        .mem_resp_valid(a_rv), .mem_resp_tag(a_rtag)
    );

    riscv_mem_arbiter_n #(.NUM_CH(4), .ADDR_BITS(32), .TAG_BITS(4), .MAX_OUTST(4)) d4 (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_ready(b_ready), .req_rw(b_rw), .req_addr(b_addr),
        .resp_valid(b_resp),
        .mem_req_valid(b_mvalid), .mem_req_ready(b_mready), .mem_req_rw(b_mrw),
        .mem_req_addr(b_maddr), .mem_req_tag(b_mtag),
        .mem_resp_valid(b_rv), .mem_resp_tag(b_rtag)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_valid = '0; a_rw = '0; a_addr = '0; a_mready = 1'b0; a_rv = 1'b0; a_rtag = '0;
        b_valid = '0; b_rw = '0; b_addr = '0; b_mready = 1'b0; b_rv = 1'b0; b_rtag = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    logic [1:0] a_rdy_exp [6];
    logic [3:0] a_tag_exp [5];
    logic [3:0] b_rdy_exp [6];
    logic [3:0] b_tag_exp [5];
    logic [2:0] a_o0_exp, a_o1_exp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef RISCV_ARB_RR_EN
        a_rdy_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        a_tag_exp = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
        b_rdy_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        b_tag_exp = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        a_o0_exp  = 3'd3;
        a_o1_exp  = 3'd3;
`else
        a_rdy_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
        a_tag_exp = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
        b_rdy_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
        b_tag_exp = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
        a_o0_exp  = 3'd4;
        a_o1_exp  = 3'd2;
`endif

        // Reset state, with requests already presented.
        reset = 1'b1;
        clear_inputs();
        tick();
        a_valid = 2'b11; a_mready = 1'b1;
        b_valid = 4'hF;  b_mready = 1'b1;
        @(negedge clk);
        check("rst_ready2", a_ready, 2'b00);
        check("rst_ready4", b_ready, 4'b0000);
        check("rst_mvalid2", a_mvalid, 1'b0);
        check("rst_outst4", d4.outst_q, 12'h000);
        check("rst_tag4", b_mtag, 4'd0);
        tick();
        reset = 1'b0;

        // All channels valid every cycle, memory always ready.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("pick_ready2", a_ready, a_rdy_exp[k]);
            check("pick_ready4", b_ready, b_rdy_exp[k]);
            check("pick_mvalid2", a_mvalid, (k > 0));
            if (k > 0) begin
                check("pick_tag2", a_mtag, a_tag_exp[k-1]);
                check("pick_tag4", b_mtag, b_tag_exp[k-1]);
            end
            tick();
        end
        @(negedge clk);
        check("pick_outst2_ch0", d2.outst_q[0], a_o0_exp);
        check("pick_outst2_ch1", d2.outst_q[1], a_o1_exp);

        // Memory stalls with a ch1 request held in the output register.
        do_reset();
        a_valid = 2'b10; a_rw = 2'b10; a_addr = {32'h0000_00A0, 32'h0};
        @(negedge clk);
        check("stall_accept", a_ready, 2'b10);
        tick();
        a_valid = 2'b11; a_addr = {32'h0000_00B0, 32'h0000_00C0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_ready", a_ready, 2'b00);
            check("stall_mvalid", a_mvalid, 1'b1);
            check("stall_addr", a_maddr, 32'h0000_00A0);
            check("stall_tag", a_mtag, 4'd1);
            check("stall_rw", a_mrw, 1'b1);
            tick();
        end
        a_mready = 1'b1;
        @(negedge clk);
        check("stall_release_ready", a_ready, 2'b01);
        tick();
        a_valid = 2'b00;
        @(negedge clk);
        check("stall_next_addr", a_maddr, 32'h0000_00C0);
        check("stall_next_tag", a_mtag, 4'd0);
        check("stall_next_rw", a_mrw, 1'b0);
        check("stall_next_resp", a_resp, 2'b00);
        tick();
        @(negedge clk);
        check("stall_drain_mvalid", a_mvalid, 1'b0);
        check("stall_outst", d2.outst_q, 6'o11);

        // Same-cycle issue and response on ch0, then stray and out-of-range responses.
        do_reset();
        b_mready = 1'b1;
        b_valid = 4'b0001; b_addr = 128'h100;
        tick();
        tick();
        b_rv = 1'b1; b_rtag = 4'd0;
        @(negedge clk);
        check("same_resp", b_resp, 4'b0001);
        check("same_ready", b_ready, 4'b0001);
        check("same_outst_before", d4.outst_q[0], 3'd2);
        tick();
        b_valid = 4'b0000;
        @(negedge clk);
        check("same_outst_after", d4.outst_q[0], 3'd2);
        tick();
        b_rtag = 4'd5;
        @(negedge clk);
        check("dec_outst", d4.outst_q[0], 3'd1);
        check("oob_resp", b_resp, 4'b0000);
        tick();
        b_rtag = 4'd2;
        @(negedge clk);
        check("oob_outst", d4.outst_q, 12'h001);
        check("stray_resp", b_resp, 4'b0100);
        tick();
        b_rv = 1'b0;
        @(negedge clk);
        check("stray_outst", d4.outst_q, 12'h001);
        tick();

        // Reset while FULL with three ch1 requests outstanding.
        do_reset();
        b_mready = 1'b1;
        b_valid = 4'b0010; b_rw = 4'b0010; b_addr = {64'h0, 32'h0000_0200, 32'h0};
        tick(); tick(); tick();
        reset = 1'b1; b_mready = 1'b0;
        @(negedge clk);
        check("midrst_outst_before", d4.outst_q[1], 3'd3);
        check("midrst_mvalid_before", b_mvalid, 1'b1);
        check("midrst_addr_before", b_maddr, 32'h0000_0200);
        check("midrst_rw_before", b_mrw, 1'b1);
        check("midrst_ready", b_ready, 4'b0000);
        tick();
        reset = 1'b0; b_valid = 4'b0000;
        @(negedge clk);
        check("midrst_mvalid_after", b_mvalid, 1'b0);
        check("midrst_outst_after", d4.outst_q, 12'h000);
        check("midrst_addr_after", b_maddr, 32'h0);
        check("midrst_tag_after", b_mtag, 4'd0);
        b_rv = 1'b1; b_rtag = 4'd1;
        @(negedge clk);
        check("postrst_resp", b_resp, 4'b0010);
        tick();
        b_rv = 1'b0;
        @(negedge clk);
        check("postrst_outst", d4.outst_q, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter_n.md
RISCV_MEM_ARBITER_N -- requirements
Module: riscv_mem_arbiter_n

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_CH, 2, number of requesting channels (channel 0 = icache, 1 = dcache by convention); range 2..2^TAG_BITS.
- ADDR_BITS, `MEM_ADDR_BITS, request address width.
- TAG_BITS, `MEM_TAG_BITS, memory tag width.
- MAX_OUTST, 4, maximum outstanding requests per channel; range 1..15.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, synchronous reset, active-high.
- req_valid, in, NUM_CH, per-channel request valid.
- req_ready, out, NUM_CH, per-channel request accept.
- req_rw, in, NUM_CH, per-channel read (0) / write (1).
- req_addr, in, NUM_CH*ADDR_BITS, per-channel address; channel i occupies bits [i*ADDR_BITS +: ADDR_BITS].
- resp_valid, out, NUM_CH, per-channel response strobe.
- mem_req_valid, out, 1, request to memory.
- mem_req_ready, in, 1, memory accepts the request.
- mem_req_rw, out, 1, forwarded rw.
- mem_req_addr, out, ADDR_BITS, forwarded address.
- mem_req_tag, out, TAG_BITS, winning channel index, zero-extended.
- mem_resp_valid, in, 1, memory response strobe.
- mem_resp_tag, in, TAG_BITS, tag of the response.

Function
REQ-003 Eligibility: channel i is eligible when req_valid[i]=1 and outst[i] < MAX_OUTST.
REQ-004 The output stage is a one-entry register with FSM states EMPTY and FULL; mem_req_valid = (state==FULL).
REQ-005 Transitions:
- EMPTY -> FULL on any channel handshake.
- FULL -> FULL on a mem_req_ready plus a new channel handshake in the same cycle.
- FULL -> EMPTY on mem_req_ready with no handshake.
- FULL with mem_req_ready=0 holds mem_req_* stable.
REQ-006 req_ready is one-hot or zero.
- req_ready[w]=1 only for the picked winner w.
- Only when state==EMPTY, or state==FULL with mem_req_ready=1.
- req_ready is combinational from the current state and inputs.
REQ-007 On handshake of w, the register SHALL load rw, addr and tag=w; mem_req_valid rises the next cycle (1-cycle latency); back-to-back issue is one request per cycle.
REQ-008 Counter width SHALL be clog2(MAX_OUTST+1); outst[i] increments on channel-i handshake and decrements on a channel-i response.
REQ-009 When a handshake and a response for the same channel occur in the same cycle, outst SHALL be unchanged.
REQ-010 Responses: resp_valid[i] = mem_resp_valid & (mem_resp_tag == i), combinational with zero latency.
REQ-011 A response with tag >= NUM_CH SHALL be dropped; no counter changes.
REQ-012 A response arriving while outst[i]==0 SHALL be routed, and the counter SHALL saturate at 0.
REQ-013 Default picker is fixed priority, lowest eligible index wins (icache over dcache).

Reset
REQ-014 While reset=1 the block SHALL set:
- state=EMPTY, mem_req_valid=0, req_ready=0;
- all outst=0, rr pointer=0;
- mem_req_rw/addr/tag registers cleared to 0.
REQ-015 Reset mid-operation discards the held request and all outstanding counts; responses arriving after reset are handled per REQ-012.

Configuration
REQ-016 With RISCV_ARB_RR_EN defined, the picker SHALL be round-robin.
- Search starts at index ptr.
- On each handshake ptr <- (w+1) mod NUM_CH.
- Without the macro, fixed priority per REQ-013 applies and ptr is not instantiated.

Structure
REQ-017 The shared package/header SHALL hold MEM_ADDR_BITS, MEM_TAG_BITS and the EMPTY/FULL state encodings.
REQ-018 The picker SHALL be sub-module riscv_arb_pick (inputs: eligible mask, ptr; output: one-hot grant), holding both the fixed and round-robin variants.

Verification
REQ-019 Bench SHALL cover:
- Fixed priority, NUM_CH=2, both valid every cycle, mem_req_ready=1 -> tags 0,0,0... until ch0 reaches 4 outstanding, then tag 1 issues.
- RISCV_ARB_RR_EN, NUM_CH=4, all valid, ready=1 -> tags 0,1,2,3,0, one per cycle, starting the cycle after the first handshake.
- mem_req_ready=0 for 3 cycles with ch1 held -> mem_req_addr/tag stable, req_ready=0 throughout; on the ready cycle a new winner is accepted.
- Same-cycle ch0 handshake and tag-0 response, outst[0]=2 -> outst[0] stays 2, resp_valid=4'b0001.
- mem_resp_tag=5 with NUM_CH=4 -> resp_valid=0 and counters unchanged.
- Reset asserted while FULL with outst[1]=3 -> next cycle mem_req_valid=0 and outst all 0.
